io_delay_multi: RTL
===================

IO_DELAY_MULTI -- requirements
Module: io_delay_multi

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of RX bitslice lanes controlled (1..16).
REQ-002 SHALL have parameter DLY_W, default 9: CNTVALUE width.
REQ-003 SHALL have parameter MAX_STEP, default 8: largest single LOAD step (1..2**DLY_W-1).
REQ-004 SHALL have parameter SETTLE_CYC, default 10: wait cycles after EN_VTC low and before EN_VTC high.
REQ-005 SHALL have parameter LOAD_WAIT, default 5: wait cycles after each LOAD pulse.
REQ-006 SHALL have ports, with LANE_W = max(1, clog2(NUM_LANES+1)):
- riu_clk  in  1  clock
- riu_rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high
- cmd_op  in  2  0=READ, 1=INC, 2=DEC, 3=UPDATE
- cmd_lane  in  LANE_W  target lane
- cmd_delay  in  DLY_W  UPDATE target value
- cntvalue_out  in  NUM_LANES*DLY_W  per-lane current delay; lane i at [i*DLY_W +: DLY_W]
- vtc_rdy  in  1  BITSLICE_CONTROL VTC_RDY
- en_vtc  out  1  shared EN_VTC
- load  out  NUM_LANES  per-lane LOAD
- ce  out  NUM_LANES  per-lane CE
- inc  out  1  shared INC
- cntvalue_in  out  DLY_W  shared new delay
- rsp_valid  out  1  one-cycle completion pulse
- rsp_lane  out  LANE_W  lane reported
- rsp_delay  out  DLY_W  final delay of that lane
- rsp_err  out  1  command rejected or saturated

Function
REQ-007 SHALL keep cmd_ready high only in IDLE and capture cmd_op, cmd_lane and cmd_delay on acceptance.
REQ-008 SHALL implement the states IDLE -> VTC_LOW -> SETTLE1 -> DECODE -> {INCDEC | CALC -> STEP -> LOAD_HI -> LOAD_WAIT -> CALC ...} -> SETTLE2 -> RESP -> VTC_HIGH -> IDLE.
REQ-009 SHALL hold in VTC_LOW until vtc_rdy is high, then drive en_vtc low.
REQ-010 SHALL spend exactly SETTLE_CYC cycles in SETTLE1.
REQ-011 SHALL latch cur from the selected lane of cntvalue_out in DECODE.
REQ-012 SHALL, for a lane index >= NUM_LANES, skip all delay activity and go DECODE -> SETTLE2 with rsp_err set.
REQ-013 SHALL have READ go DECODE -> SETTLE2 with no load or ce activity.
REQ-014 SHALL have INC/DEC assert ce[lane] for exactly one cycle, with inc = 1 for INC and 0 for DEC.
REQ-015 SHALL suppress the ce pulse and set rsp_err when INC is issued at cur = all-ones or DEC at cur = 0.
REQ-016 SHALL compute in CALC diff = |cmd_delay - cur| at DLY_W bits with no wrap, and set direction up if cmd_delay > cur.
REQ-017 SHALL go to SETTLE2 when diff = 0.
REQ-018 SHALL compute in STEP step = min(diff, MAX_STEP) and cntvalue_in = cur +/- step.
REQ-019 SHALL pulse load[lane] for exactly one cycle in LOAD_HI.
REQ-020 SHALL wait exactly LOAD_WAIT cycles in LOAD_WAIT, re-latch cur from cntvalue_out, then return to CALC.
REQ-021 SHALL, in SETTLE2, wait SETTLE_CYC cycles and re-sample the lane into rsp_delay on every cycle.
REQ-022 SHALL, in RESP, pulse rsp_valid for one cycle with rsp_lane and rsp_err.
REQ-023 SHALL, in VTC_HIGH, drive en_vtc high and return to IDLE.
REQ-024 SHALL never assert load or ce on a non-selected lane, and SHALL never assert load and ce in the same cycle.
REQ-025 SHALL hold cntvalue_in stable from STEP through the end of LOAD_HI.
REQ-026 SHALL ignore cmd_valid while not in IDLE; a new command is accepted no earlier than the cycle after VTC_HIGH.

Reset
REQ-027 SHALL, on riu_rst at any time including mid-command, immediately set state=IDLE, en_vtc=1, load=0, ce=0, inc=0, cntvalue_in=0, rsp_valid=0, rsp_lane=0, rsp_delay=0, rsp_err=0 and cmd_ready=0 while reset is asserted.
REQ-028 SHALL set cmd_ready to 1 on the first cycle after reset release, and SHALL drop any in-flight command without a response.

Configuration
REQ-029 SHALL, with IO_DELAY_BROADCAST_EN defined, treat cmd_lane = NUM_LANES as broadcast.
REQ-030 SHALL, for broadcast, run the DECODE..LOAD_WAIT sequence for lanes 0..NUM_LANES-1 in order within one VTC_LOW/VTC_HIGH window.
REQ-031 SHALL, for broadcast, return one RESP with rsp_lane = NUM_LANES, rsp_delay = lane 0 final value, and rsp_err as the OR over all lanes.
REQ-032 SHALL, without IO_DELAY_BROADCAST_EN, reject cmd_lane = NUM_LANES per REQ-012.

Verification
REQ-033 SHALL cover READ on lane 2 with cntvalue_out lane 2 = 100 and vtc_rdy high -> rsp_delay = 100, rsp_err = 0, no load/ce, en_vtc low for 2*SETTLE_CYC plus fixed overhead cycles.
REQ-034 SHALL cover UPDATE on lane 1 from 10 to 30 with a model that tracks LOAD -> load pulses with cntvalue_in 18, 26, 30, LOAD_WAIT gaps, rsp_delay = 30.
REQ-035 SHALL cover DEC on lane 0 at cur = 0 -> no ce pulse, rsp_err = 1; then INC at cur = 5 -> one ce with inc = 1, rsp_delay = 6.
REQ-036 SHALL cover vtc_rdy held low 50 cycles after acceptance -> en_vtc stays high and the FSM stays in VTC_LOW, then proceeds normally after vtc_rdy rises.
REQ-037 SHALL cover riu_rst asserted during LOAD_WAIT of a 0 -> 200 UPDATE -> en_vtc = 1, load = 0 immediately, no rsp_valid, and the next command completes normally.
REQ-038 SHALL cover, with IO_DELAY_BROADCAST_EN, UPDATE to 40 broadcast over 4 lanes at 0/40/50/300 -> lanes converge to 40 in order, single rsp_valid, rsp_lane = 4.

Source files
------------

// File: rtl/io_delay_multi.sv
// ---------------------------------------------------------------------------
// io_delay_multi
//
// Purpose: RIU-side controller that moves the delay taps of several RX
// bitslice lanes. A command freezes voltage/temperature compensation
// (EN_VTC low), lets it settle, then reads, nudges (INC/DEC) or walks a
// lane towards a target value using bounded LOAD steps, settles again,
// reports the lane's final delay and finally re-enables VTC.
//
// Ports:
//   riu_clk, riu_rst      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op                0=READ 1=INC 2=DEC 3=UPDATE
//   cmd_lane, cmd_delay   target lane and UPDATE target value
//   cntvalue_out          per-lane current delay (lane i at [i*DLY_W +: DLY_W])
//   vtc_rdy               BITSLICE_CONTROL VTC_RDY
//   en_vtc                shared EN_VTC
//   load, ce              per-lane LOAD and CE strobes
//   inc, cntvalue_in      shared INC direction and LOAD value
//   rsp_valid             one-cycle completion pulse
//   rsp_lane, rsp_delay   lane reported and its final delay
//   rsp_err               command rejected or saturated
//
// Optional feature: define IO_DELAY_BROADCAST_EN to treat
// cmd_lane == NUM_LANES as "all lanes, in order, in one VTC window".
// Without it, that lane index is rejected like any other invalid lane.
// ---------------------------------------------------------------------------
module io_delay_multi #(
    parameter int NUM_LANES  = 4,
    parameter int DLY_W      = 9,
    parameter int MAX_STEP   = 8,
    parameter int SETTLE_CYC = 10,
    parameter int LOAD_WAIT  = 5,
    localparam int LANE_W    = ($clog2(NUM_LANES + 1) > 1) ? $clog2(NUM_LANES + 1) : 1
) (
    input  logic                       riu_clk,
    input  logic                       riu_rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [LANE_W-1:0]          cmd_lane,
    input  logic [DLY_W-1:0]           cmd_delay,
    input  logic [NUM_LANES*DLY_W-1:0] cntvalue_out,
    input  logic                       vtc_rdy,
    output logic                       en_vtc,
    output logic [NUM_LANES-1:0]       load,
    output logic [NUM_LANES-1:0]       ce,
    output logic                       inc,
    output logic [DLY_W-1:0]           cntvalue_in,
    output logic                       rsp_valid,
    output logic [LANE_W-1:0]          rsp_lane,
    output logic [DLY_W-1:0]           rsp_delay,
    output logic                       rsp_err
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_VTC_LOW   = 4'd1;
    localparam logic [3:0] S_SETTLE1   = 4'd2;
    localparam logic [3:0] S_DECODE    = 4'd3;
    localparam logic [3:0] S_INCDEC    = 4'd4;
    localparam logic [3:0] S_CALC      = 4'd5;
    localparam logic [3:0] S_STEP      = 4'd6;
    localparam logic [3:0] S_LOAD_HI   = 4'd7;
    localparam logic [3:0] S_LOAD_WAIT = 4'd8;
    localparam logic [3:0] S_SETTLE2   = 4'd9;
    localparam logic [3:0] S_RESP      = 4'd10;
    localparam logic [3:0] S_VTC_HIGH  = 4'd11;

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_INC    = 2'd1;
    localparam logic [1:0] OP_DEC    = 2'd2;
    localparam logic [1:0] OP_UPDATE = 2'd3;

    localparam logic [LANE_W-1:0] LANE_BCAST  = LANE_W'(NUM_LANES);
    localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(NUM_LANES - 1);
    localparam logic [DLY_W-1:0]  STEP_MAX    = DLY_W'(MAX_STEP);
    localparam logic [15:0]       SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0]       WAIT_LAST   = 16'(LOAD_WAIT - 1);

    logic [3:0]           state;
    logic [15:0]          cnt;
    logic [1:0]           op_q;
    logic [LANE_W-1:0]    lane_q;
    logic [DLY_W-1:0]     delay_q;
    logic [LANE_W-1:0]    work_lane;
    logic [DLY_W-1:0]     cur;
    logic [DLY_W-1:0]     diff;
    logic                 up;
    logic                 err;

    logic                 bcast_new;
    logic                 bcast_q;
    logic                 lane_ok;
    logic                 rsp_ok;
    logic                 more_lanes;
    logic                 inc_sat;
    logic [3:0]           done_state;
    logic [LANE_W-1:0]    rsp_sel;
    logic [DLY_W-1:0]     cur_val;
    logic [DLY_W-1:0]     rsp_val;
    logic [DLY_W-1:0]     step;
    logic [NUM_LANES-1:0] lane_mask;

    // Returns the delay of one lane; out-of-range selects read as zero.
    function automatic logic [DLY_W-1:0] lane_value(input logic [LANE_W-1:0] sel,
                                                     input logic [NUM_LANES*DLY_W-1:0] bus);
        lane_value = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (sel == LANE_W'(i)) lane_value = bus[i*DLY_W +: DLY_W];
        end
    endfunction

`ifdef IO_DELAY_BROADCAST_EN
    assign bcast_new = (cmd_lane == LANE_BCAST);
    assign bcast_q   = (lane_q == LANE_BCAST);
`else
    assign bcast_new = 1'b0;
    assign bcast_q   = 1'b0;
`endif

    // A broadcast walks work_lane 0..NUM_LANES-1; a lane finishing early
    // either moves on to the next lane or closes the VTC window.
    assign more_lanes = bcast_q && (work_lane != LANE_LAST);
    assign done_state = more_lanes ? S_DECODE : S_SETTLE2;
    assign lane_ok    = (work_lane < LANE_BCAST);
    assign rsp_sel    = bcast_q ? '0 : lane_q;
    assign rsp_ok     = bcast_q || (lane_q < LANE_BCAST);
    assign cur_val    = lane_value(work_lane, cntvalue_out);
    assign rsp_val    = lane_value(rsp_sel, cntvalue_out);
    assign step       = (diff > STEP_MAX) ? STEP_MAX : diff;
    assign inc_sat    = ((op_q == OP_INC) && (cur_val == '1)) ||
                        ((op_q == OP_DEC) && (cur_val == '0));
    assign rsp_err    = err;

    // One-hot strobe pattern for the lane currently being worked on.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_mask[i] = (work_lane == LANE_W'(i));
        end
    end

    // Command sequencer. All outputs are registered so strobes are glitch
    // free; a strobe set on entry to a state is visible for exactly that
    // state's single cycle (ce in INCDEC, load in LOAD_HI).
    always_ff @(posedge riu_clk or posedge riu_rst) begin
        if (riu_rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_q        <= '0;
            lane_q      <= '0;
            delay_q     <= '0;
            work_lane   <= '0;
            cur         <= '0;
            diff        <= '0;
            up          <= 1'b0;
            err         <= 1'b0;
            cmd_ready   <= 1'b0;
            en_vtc      <= 1'b1;
            load        <= '0;
            ce          <= '0;
            inc         <= 1'b0;
            cntvalue_in <= '0;
            rsp_valid   <= 1'b0;
            rsp_lane    <= '0;
            rsp_delay   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op;
                        lane_q    <= cmd_lane;
                        delay_q   <= cmd_delay;
                        work_lane <= bcast_new ? '0 : cmd_lane;
                        err       <= 1'b0;
                        state     <= S_VTC_LOW;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_VTC_LOW: begin
                    if (vtc_rdy) begin
                        en_vtc <= 1'b0;
                        cnt    <= '0;
                        state  <= S_SETTLE1;
                    end
                end
                S_SETTLE1: begin
                    if (cnt == SETTLE_LAST) state <= S_DECODE;
                    else                    cnt   <= cnt + 16'd1;
                end
                S_DECODE: begin
                    cur <= cur_val;
                    if (!lane_ok || (op_q == OP_READ) ||
                        (((op_q == OP_INC) || (op_q == OP_DEC)) && inc_sat)) begin
                        if (!lane_ok || inc_sat) err <= 1'b1;
                        state     <= done_state;
                        work_lane <= work_lane + LANE_W'(more_lanes);
                        cnt       <= '0;
                    end else if (op_q == OP_UPDATE) begin
                        state <= S_CALC;
                    end else begin
                        ce    <= lane_mask;
                        inc   <= (op_q == OP_INC);
                        state <= S_INCDEC;
                    end
                end
                S_INCDEC: begin
                    ce        <= '0;
                    inc       <= 1'b0;
                    state     <= done_state;
                    work_lane <= work_lane + LANE_W'(more_lanes);
                    cnt       <= '0;
                end
                S_CALC: begin
                    if (delay_q == cur) begin
                        state     <= done_state;
                        work_lane <= work_lane + LANE_W'(more_lanes);
                        cnt       <= '0;
                    end else begin
                        up    <= (delay_q > cur);
                        diff  <= (delay_q > cur) ? (delay_q - cur) : (cur - delay_q);
                        state <= S_STEP;
                    end
                end
                S_STEP: begin
                    cntvalue_in <= up ? (cur + step) : (cur - step);
                    load        <= lane_mask;
                    state       <= S_LOAD_HI;
                end
                S_LOAD_HI: begin
                    load  <= '0;
                    cnt   <= '0;
                    state <= S_LOAD_WAIT;
                end
                S_LOAD_WAIT: begin
                    // Re-read the lane rather than trusting cntvalue_in, so
                    // the walk converges on what the bitslice actually holds.
                    if (cnt == WAIT_LAST) begin
                        cur   <= cur_val;
                        state <= S_CALC;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_SETTLE2: begin
                    rsp_delay <= rsp_ok ? rsp_val : '0;
                    if (cnt == SETTLE_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_lane  <= lane_q;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b0;
                    en_vtc    <= 1'b1;
                    state     <= S_VTC_HIGH;
                end
                S_VTC_HIGH: begin
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
